uart_rcv_block: RTL and testbench

// - UART-style serial receiver; the receive-side counterpart of the team's parallel-to-serial transmit path.
// - Frame: idle-high line, 1 start bit (0), NUM_DATA_BITS data bits LSB first, 1 stop bit (1).
// - Samples each bit at mid-bit and presents the received word on a parallel bus with ready/overrun/framing flags.
// - A downstream consumer acknowledges each word with data_read.

---
 rtl/uart_rcv_block.sv | 174 +++++++++++++++++
 tb/tb_uart_rcv_block.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv_block.sv
// uart_rcv_block -- UART-style serial receiver.
//
// Frame on serial_in: idle high, one start bit (0), NUM_DATA_BITS data bits
// LSB first, one stop bit (1). Each bit is sampled at mid-bit. A good frame
// is presented on rx_data with data_ready set. The consumer pulses data_read
// to acknowledge the word.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   n_rst          synchronous active-low reset
//   serial_in      asynchronous serial line (idle high)
//   data_read      consumer ack; clears data_ready / overrun_error
//   rx_data        last good received word
//   data_ready     rx_data holds an unread word
//   overrun_error  an unread word was overwritten by a new one
//   framing_error  last frame had a stop bit of 0; held until the next
//                  valid start bit
module uart_rcv_block #(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     data_read,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     overrun_error,
    output logic                     framing_error
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

    // The timer starts at 0 on the cycle after a state change, so a compare
    // against N-1 lands on the Nth cycle of that state.
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NUM_DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]               sync_q, sync_d;
    logic                     s_prev_q, s_prev_d;
    logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                     ready_q, ready_d;
    logic                     ovr_q, ovr_d;
    logic                     fe_q, fe_d;

    logic s;
    logic load;

    assign s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        fe_d      = fe_q;
        sync_d    = {sync_q[0], serial_in};
        s_prev_d  = s;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                // Only IDLE looks for a falling edge; line activity inside a
                // frame never restarts it.
                if (!s && s_prev_q) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    if (s) begin
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        timer_d   = '0;
                        bit_cnt_d = '0;
                        fe_d      = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    // LSB arrives first, so shifting right with the sample
                    // entering at the MSB leaves the word in natural order.
                    shift_d = shift_q >> 1;
                    shift_d[NUM_DATA_BITS-1] = s;
                    if (bit_cnt_q == B_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == T_FULL) begin
                    // Leave half a bit early so a back-to-back start edge
                    // is seen.
                    state_d = IDLE;
                    timer_d = '0;
                    if (s) begin
                        load = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load wins over a simultaneous ack; the old word counts as read,
        // so overrun is only flagged when it was still unread.
        if (load) begin
            rx_data_d = shift_d;
            ready_d   = 1'b1;
            ovr_d     = ready_q & ~data_read;
        end else if (data_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '1;
            sync_q    <= 2'b11;
            s_prev_q  <= 1'b1;
            rx_data_q <= '1;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = ovr_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rcv_block.sv
// Testbench for uart_rcv_block. The frame driver announces, for each frame
// it sends, the clock edges at which the start-bit check and the stop-bit
// result must take effect. A frame-level model applies those events plus the
// data_read/reset rules, and is compared with the DUT on every falling edge.
// Literal checks at scenario boundaries pin the model.
module tb_uart_rcv_block;

    localparam int N    = 8;
    localparam int CLKS = 10;
    localparam int HALF = CLKS / 2;
    // Line falls after edge t0: the synchronizer plus edge detect give the
    // start edge during the cycle after edge t0+2.
    localparam int CLR_OFS  = 3 + HALF;                  // start-bit accepted
    localparam int LOAD_OFS = 3 + HALF + (N + 1) * CLKS; // stop-bit result (98)

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         serial_in = 1'b1;
    logic         data_read = 1'b0;
    logic [N-1:0] rx_data;
    logic         data_ready, overrun_error, framing_error;

    uart_rcv_block #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(CLKS)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    // kind: 0 = start bit accepted, 1 = good stop, 2 = bad stop
    typedef struct {
        int           at;
        int           kind;
        logic [N-1:0] d;
    } ev_t;

    ev_t evq[$];

    int           cyc = 0;
    int           errs = 0;
    int           checks = 0;
    bit           chk_en = 1'b0;
    logic [N-1:0] m_rx = '1;
    logic         m_rdy = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

    int               lit_seq = 0;
    int               lit_done = 0;
    string            lit_name = "";
    logic [N+2:0]     lit_exp = '0;

    // Frame-level model.
    always @(posedge clk) begin : model
        logic         ld, fe_set, fe_clr;
        logic [N-1:0] ld_d;
        ld = 1'b0; fe_set = 1'b0; fe_clr = 1'b0; ld_d = '0;
        foreach (evq[i]) begin
            if (evq[i].at == cyc + 1) begin
                case (evq[i].kind)
                    0:       fe_clr = 1'b1;
                    1:       begin ld = 1'b1; ld_d = evq[i].d; end
                    default: fe_set = 1'b1;
                endcase
            end
        end
        cyc <= cyc + 1;
        if (!n_rst) begin
            m_rx  <= '1;
            m_rdy <= 1'b0;
            m_ovr <= 1'b0;
            m_fe  <= 1'b0;
            evq.delete();
        end else begin
            if (ld) begin
                m_rx  <= ld_d;
                m_rdy <= 1'b1;
                m_ovr <= m_rdy && !data_read;
            end else if (data_read) begin
                m_rdy <= 1'b0;
                m_ovr <= 1'b0;
            end
            if (fe_set)      m_fe <= 1'b1;
            else if (fe_clr) m_fe <= 1'b0;
        end
    end

    // Single compare process: model every cycle, plus pending literal checks.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({rx_data, data_ready, overrun_error, framing_error} !==
                {m_rx, m_rdy, m_ovr, m_fe}) begin
                errs++;
                $display("FAIL cycle_model cyc=%0d got rx=%h rdy=%b ovr=%b fe=%b want rx=%h rdy=%b ovr=%b fe=%b",
                         cyc, rx_data, data_ready, overrun_error, framing_error,
                         m_rx, m_rdy, m_ovr, m_fe);
            end
            if (lit_seq != lit_done) begin
                lit_done = lit_seq;
                checks++;
                if ({rx_data, data_ready, overrun_error, framing_error} !== lit_exp) begin
                    errs++;
                    $display("FAIL %s got rx=%h rdy=%b ovr=%b fe=%b want rx=%h rdy=%b ovr=%b fe=%b",
                             lit_name, rx_data, data_ready, overrun_error, framing_error,
                             lit_exp[N+2:3], lit_exp[2], lit_exp[1], lit_exp[0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic lit(input string nm, input logic [N-1:0] rx,
                       input logic rdy, input logic ovr, input logic fe);
        lit_name = nm;
        lit_exp  = {rx, rdy, ovr, fe};
        lit_seq++;
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        idle(2);
        n_rst = 1'b1;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        idle(1);
        data_read = 1'b0;
    endtask

    // Drives one frame starting now. abort_at>0 resets mid-frame after that
    // many cycles; rd_at_load raises data_read for the stop-result edge.
    task automatic send_frame(input logic [N-1:0] d, input logic stopb,
                              input int abort_at, input bit rd_at_load);
        int           t0;
        int           k;
        logic [N+1:0] bits;
        t0   = cyc;
        k    = 0;
        bits = {stopb, d, 1'b0};
        evq.push_back('{t0 + CLR_OFS, 0, d});
        evq.push_back('{t0 + LOAD_OFS, stopb ? 1 : 2, d});
        for (int i = 0; i < N + 2; i++) begin
            serial_in = bits[i];
            for (int j = 0; j < CLKS; j++) begin
                if (abort_at != 0 && k == abort_at) begin
                    serial_in = 1'b1;
                    do_reset();
                    return;
                end
                data_read = rd_at_load && (cyc == t0 + LOAD_OFS - 1);
                idle(1);
                k++;
            end
        end
        serial_in = 1'b1;
        data_read = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        lit("reset", 8'hFF, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 1'b1, 0, 1'b0);
        lit("rx_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        pulse_read();
        lit("a5_read", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 0, 1'b0);
        lit("framing_3c", 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(3);
        send_frame(8'h11, 1'b1, 0, 1'b0);
        lit("rx_11", 8'h11, 1'b1, 1'b0, 1'b0);
        pulse_read();

        send_frame(8'h55, 1'b1, 0, 1'b0);
        send_frame(8'hC3, 1'b1, 0, 1'b0);
        lit("overrun_c3", 8'hC3, 1'b1, 1'b1, 1'b0);
        pulse_read();
        lit("overrun_read", 8'hC3, 1'b0, 1'b0, 1'b0);

        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(30);
        lit("glitch", 8'hC3, 1'b0, 1'b0, 1'b0);

        send_frame(8'h42, 1'b1, 0, 1'b0);
        lit("rx_42", 8'h42, 1'b1, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1, 0, 1'b1);
        lit("load_and_read_7e", 8'h7E, 1'b1, 1'b0, 1'b0);

        send_frame(8'h99, 1'b1, 40, 1'b0);
        lit("reset_mid_frame", 8'hFF, 1'b0, 1'b0, 1'b0);
        idle(5);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        lit("rx_5a_after_reset", 8'h5A, 1'b1, 1'b0, 1'b0);
        do_reset();
        lit("reset_idle", 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
